clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Parametrised clock-divider and enable generator that replaces the fixed divide-by-4 pixel-clock divider. It produces a registered 50%-class divided clock, a one-cycle rising-edge tick for clock-enable use, and accepts run-time divide-ratio changes. Ratio changes are applied glitch-free at a period boundary. It sits between the board clock and the VGA timing and pixel pipelines; downstream logic should use `tick` as an enable rather than clocking from `clk_out`.

## Interface
- `DIV_W`, 8: width of the ratio and phase counter.
- `DIV_DEFAULT`, 4: ratio after reset. Must be in range 2..2^DIV_W-1.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable. When low, counter and outputs are frozen.
- `sclr`  input  1  synchronous phase clear.
- `div_load`  input  1  ratio-load strobe.
- `div_in`  input  DIV_W  requested ratio, sampled when `div_load`=1.
- `clk_out`  output  1  registered divided clock.
- `tick`  output  1  one-cycle strobe on each `clk_out` rising phase.
- `phase`  output  DIV_W  current counter value.
- `div_cur`  output  DIV_W  ratio currently in force.
- `pend`  output  1  an accepted ratio is waiting for a boundary.
- `ack`  output  1  one-cycle pulse: new ratio applied.
- `err`  output  1  one-cycle pulse: load rejected.

## Operation
- Counter `phase` runs 0..div_cur-1 and advances only when `en`=1. A wrap is the cycle where `en`=1 and `phase`=div_cur-1; the next value is 0.
- `clk_out` = (phase >= div_cur>>1).
  - Held in a flop, so it is glitch-free.
  - div=4 gives 0,0,1,1. div=5 gives 0,0,1,1,1.
- `tick` = 1 exactly in cycles where `en`=1 and phase = div_cur>>1, i.e. the first high cycle of `clk_out`.
- Load path:
  - A `div_load` with div_in < 2 is rejected: `err` pulses the next cycle, with no other effect.
  - A valid load writes the pending register and sets `pend`.
  - A later valid load overwrites the pending value (last wins).
- Apply:
  - At a wrap, or at `sclr`, with a pending or same-cycle valid load, `div_cur` takes the new value and `phase` goes to 0.
  - `pend` clears and `ack` pulses one cycle later.
  - A valid load in the wrap cycle itself is applied at that wrap.
- `sclr` forces phase=0 and `clk_out`=0 next cycle, has priority over `en`, and applies any pending ratio.
- With `en`=0: phase, clk_out and div_cur hold, tick=0, and loads are still accepted into pending.
- A shrinking ratio never overshoots: the old ratio is in force until the wrap.

## Timing
- Reset (reset=0, asynchronous) values:
  - phase=0, clk_out=0, tick=0, div_cur=DIV_DEFAULT.
  - pend=0, ack=0, err=0, pending register = DIV_DEFAULT.
- Reset asserted mid-period or with `pend` set discards the pending ratio. No ack or err follows.
- Every output is a flop output, with no combinational path from inputs to outputs.
- Load-to-apply latency is 1 to div_cur enabled cycles. `ack` is high in the first cycle of the new period (phase=0, new div_cur).
- `err` appears one cycle after the rejected `div_load`.

## Structure
- Package `clk_div_pkg` contains:
  - `DIV_MIN`=2
  - `DIV_VGA25`=4
  - a typedef for a DIV_W-bit ratio type, default width 8
- One natural sub-module, `clk_div_ctl`, owns the pending register, validity check and ack/err generation. The counter and output flops stay in the top module.

## Test plan
- Reset release, en=1, default 4 -> clk_out 0,0,1,1 repeating; tick at phase 2 every 4th cycle; div_cur=4.
- At phase=1, load 5 -> pend=1; after the wrap from phase 3, ack=1 with phase=0 and div_cur=5; clk_out 0,0,1,1,1.
- Load 1, then load 0 -> err pulses once per load; div_cur and phase are unaffected; pend stays 0.
- Load 8 then load 2 within one period, under div=6 -> only ratio 2 is applied at the wrap; a single ack; clk_out 0,1 alternating.
- en=0 for 7 cycles at phase 3 (div=4), then en=1 -> phase holds 3, clk_out holds 1, no ticks; resumes at phase 0 next.
- Assert reset while pend=1, mid-period -> all outputs go to reset values immediately; after release, div_cur=4 and no ack.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and ratio type for the clock divider
package clk_div_pkg;
    localparam int DIV_MIN       = 2;
    localparam int DIV_VGA25     = 4;
    localparam int DIV_W_DEFAULT = 8;

    typedef logic [DIV_W_DEFAULT-1:0] div_ratio_t;
endpackage

// File: rtl/clk_div_ctl.sv
// rtl/clk_div_ctl.sv - pending ratio register, load validation, ack/err pulses
module clk_div_ctl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = DIV_VGA25
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_div_load,
    input  logic [DIV_W-1:0] i_div_in,
    input  logic             i_apply,
    output logic [DIV_W-1:0] o_new_div,
    output logic             o_have_new,
    output logic             o_pend,
    output logic             o_ack,
    output logic             o_err
);
    localparam logic [DIV_W-1:0] W_MIN = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] W_DEF = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] r_pending;
    logic             r_pend;
    logic             r_ack;
    logic             r_err;
    logic             w_valid;

    assign w_valid    = i_div_load && (i_div_in >= W_MIN);
    // A load landing in the boundary cycle bypasses the pending register.
    assign o_have_new = r_pend || w_valid;
    assign o_new_div  = w_valid ? i_div_in : r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= W_DEF;
            r_pend    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= i_div_load && !w_valid;
            r_ack <= i_apply;
            if (w_valid) begin
                r_pending <= i_div_in;
            end
            r_pend <= i_apply ? 1'b0 : (r_pend || w_valid);
        end
    end

    assign o_pend = r_pend;
    assign o_ack  = r_ack;
    assign o_err  = r_err;
endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - parametrised clock divider with tick enable and run-time ratio change
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = DIV_VGA25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sclr,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] phase,
    output logic [DIV_W-1:0] div_cur,
    output logic             pend,
    output logic             ack,
    output logic             err
);
    localparam logic [DIV_W-1:0] W_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] W_DEF = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_div_cur;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_wrap;
    logic             w_boundary;
    logic             w_apply;
    logic             w_have_new;
    logic [DIV_W-1:0] w_new_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_phase_nxt;

    clk_div_ctl #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ctl (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_div_load (div_load),
        .i_div_in   (div_in),
        .i_apply    (w_apply),
        .o_new_div  (w_new_div),
        .o_have_new (w_have_new),
        .o_pend     (pend),
        .o_ack      (ack),
        .o_err      (err)
    );

    assign w_wrap     = en && (r_phase == (r_div_cur - W_ONE));
    assign w_boundary = sclr || w_wrap;
    assign w_apply    = w_boundary && w_have_new;

    always_comb begin
        w_div_nxt   = w_apply ? w_new_div : r_div_cur;
        w_phase_nxt = r_phase;
        if (w_boundary) begin
            w_phase_nxt = '0;
        end else if (en) begin
            w_phase_nxt = r_phase + W_ONE;
        end
    end

    // Outputs are computed from next-state so clk_out and tick line up with phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase   <= '0;
            r_div_cur <= W_DEF;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_div_cur <= w_div_nxt;
            r_tick    <= en && !sclr && (w_phase_nxt == (w_div_nxt >> 1));
            if (sclr || en) begin
                r_clk_out <= (w_phase_nxt >= (w_div_nxt >> 1));
            end
        end
    end

    assign phase   = r_phase;
    assign div_cur = r_div_cur;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - scoreboard bench for clk_div_gen with directed vectors
module tb_clk_div_gen;
    import clk_div_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       sclr = 1'b0;
    logic       div_load = 1'b0;
    div_ratio_t div_in = '0;
    logic       clk_out;
    logic       tick;
    div_ratio_t phase;
    div_ratio_t div_cur;
    logic       pend;
    logic       ack;
    logic       err;

    typedef struct {
        int idx;
        int ph;
        int ck;
        int tk;
        int dv;
        int pd;
        int ak;
        int er;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_n = 0;

    clk_div_gen #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sclr     (sclr),
        .div_load (div_load),
        .div_in   (div_in),
        .clk_out  (clk_out),
        .tick     (tick),
        .phase    (phase),
        .div_cur  (div_cur),
        .pend     (pend),
        .ack      (ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, act, want);
        end
    endtask

    task automatic v(input int e, input int s, input int l, input int d,
                     input int ph, input int ck, input int tk, input int dv,
                     input int pd, input int ak, input int er);
        exp_t x;
        @(negedge clk);
        en       = e[0];
        sclr     = s[0];
        div_load = l[0];
        div_in   = 8'(d);
        x = '{vec_n, ph, ck, tk, dv, pd, ak, er};
        q.push_back(x);
        vec_n++;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("phase",   x.idx, int'(phase),   x.ph);
                check("clk_out", x.idx, int'(clk_out), x.ck);
                check("tick",    x.idx, int'(tick),    x.tk);
                check("div_cur", x.idx, int'(div_cur), x.dv);
                check("pend",    x.idx, int'(pend),    x.pd);
                check("ack",     x.idx, int'(ack),     x.ak);
                check("err",     x.idx, int'(err),     x.er);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(input int idx);
        check("rst_phase",   idx, int'(phase),   0);
        check("rst_clk_out", idx, int'(clk_out), 0);
        check("rst_tick",    idx, int'(tick),    0);
        check("rst_div_cur", idx, int'(div_cur), 4);
        check("rst_pend",    idx, int'(pend),    0);
        check("rst_ack",     idx, int'(ack),     0);
        check("rst_err",     idx, int'(err),     0);
    endtask

    initial begin
        #12;
        check_reset(0);
        @(negedge clk);
        reset = 1'b1;

        // default ratio 4
        for (int k = 0; k < 2; k++) begin
            v(1,0,0,0, 1,0,0,4,0,0,0);
            v(1,0,0,0, 2,1,1,4,0,0,0);
            v(1,0,0,0, 3,1,0,4,0,0,0);
            v(1,0,0,0, 0,0,0,4,0,0,0);
        end
        // load 5 at phase 1, applied at wrap
        v(1,0,0,0, 1,0,0,4,0,0,0);
        v(1,0,1,5, 2,1,1,4,1,0,0);
        v(1,0,0,0, 3,1,0,4,1,0,0);
        v(1,0,0,0, 0,0,0,5,0,1,0);
        v(1,0,0,0, 1,0,0,5,0,0,0);
        v(1,0,0,0, 2,1,1,5,0,0,0);
        v(1,0,0,0, 3,1,0,5,0,0,0);
        v(1,0,0,0, 4,1,0,5,0,0,0);
        v(1,0,0,0, 0,0,0,5,0,0,0);
        // rejected loads 1 and 0
        v(1,0,1,1, 1,0,0,5,0,0,1);
        v(1,0,1,0, 2,1,1,5,0,0,1);
        v(1,0,0,0, 3,1,0,5,0,0,0);
        v(1,0,0,0, 4,1,0,5,0,0,0);
        v(1,0,0,0, 0,0,0,5,0,0,0);
        // move to ratio 6
        v(1,0,1,6, 1,0,0,5,1,0,0);
        v(1,0,0,0, 2,1,1,5,1,0,0);
        v(1,0,0,0, 3,1,0,5,1,0,0);
        v(1,0,0,0, 4,1,0,5,1,0,0);
        v(1,0,0,0, 0,0,0,6,0,1,0);
        // load 8 then 2 within one period: last wins
        v(1,0,1,8, 1,0,0,6,1,0,0);
        v(1,0,1,2, 2,0,0,6,1,0,0);
        v(1,0,0,0, 3,1,1,6,1,0,0);
        v(1,0,0,0, 4,1,0,6,1,0,0);
        v(1,0,0,0, 5,1,0,6,1,0,0);
        v(1,0,0,0, 0,0,0,2,0,1,0);
        v(1,0,0,0, 1,1,1,2,0,0,0);
        v(1,0,0,0, 0,0,0,2,0,0,0);
        v(1,0,0,0, 1,1,1,2,0,0,0);
        v(1,0,0,0, 0,0,0,2,0,0,0);
        // back to 4, then freeze at phase 3
        v(1,0,1,4, 1,1,1,2,1,0,0);
        v(1,0,0,0, 0,0,0,4,0,1,0);
        v(1,0,0,0, 1,0,0,4,0,0,0);
        v(1,0,0,0, 2,1,1,4,0,0,0);
        v(1,0,0,0, 3,1,0,4,0,0,0);
        for (int k = 0; k < 7; k++) begin
            v(0,0,0,0, 3,1,0,4,0,0,0);
        end
        v(1,0,0,0, 0,0,0,4,0,0,0);
        v(1,0,0,0, 1,0,0,4,0,0,0);
        // sclr with same-cycle load, then load in the wrap cycle
        v(1,1,1,3, 0,0,0,3,0,1,0);
        v(1,0,0,0, 1,1,1,3,0,0,0);
        v(1,0,0,0, 2,1,0,3,0,0,0);
        v(1,0,1,4, 0,0,0,4,0,1,0);
        v(1,0,0,0, 1,0,0,4,0,0,0);
        v(1,1,0,0, 0,0,0,4,0,0,0);
        // loads accepted while disabled
        v(0,0,1,5, 0,0,0,4,1,0,0);
        v(0,0,0,0, 0,0,0,4,1,0,0);
        v(1,0,0,0, 1,0,0,4,1,0,0);

        // async reset mid-period with pend set
        @(posedge clk);
        #3;
        en = 1'b0;
        reset = 1'b0;
        #1;
        check_reset(vec_n);
        @(negedge clk);
        reset = 1'b1;
        v(1,0,0,0, 1,0,0,4,0,0,0);
        v(1,0,0,0, 2,1,1,4,0,0,0);
        v(1,0,0,0, 3,1,0,4,0,0,0);
        v(1,0,0,0, 0,0,0,4,0,0,0);
        v(1,0,0,0, 1,0,0,4,0,0,0);

        @(posedge clk);
        #3;
        check("drain", vec_n, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
